// File: rtl/pak_rv_pkg.sv
// Shared types for the pak-rv fetch path: the buffered fetch entry and counter sizing.
package pak_rv_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned XLEN        = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Counters must hold the value FIFO_DEPTH itself, hence the extra bit.
    function automatic int unsigned fetch_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pak_rv_fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; DEPTH must be a power of 2. Flush beats push/pop.
module pak_rv_fetch_fifo
    import pak_rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = fetch_cnt_w(DEPTH),
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pak_rv_fetch_unit.sv
// Decoupled fetch front end: credit-limited imem requests, PC-tagged prefetch FIFO, redirect/flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters. DATA_WIDTH up to 32.
module pak_rv_fetch_unit
    import pak_rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IMEM_SZ_IN_KB = 1,
    parameter int unsigned RESET_PC      = 0,
    parameter int unsigned FIFO_DEPTH    = 4,
    localparam int unsigned PC_SIZE = $clog2(IMEM_SZ_IN_KB * 1024)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_SIZE-1:0]    imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [PC_SIZE-1:0]    redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [PC_SIZE-1:0]    if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushed
`endif
);

    localparam int unsigned CW = fetch_cnt_w(FIFO_DEPTH);

    logic [PC_SIZE-1:0] fetch_pc;
    logic [PC_SIZE-1:0] rsp_pc;
    logic [PC_SIZE-1:0] redirect_base;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_after;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      count;
    logic               req_fire;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;
    logic               unused_redirect_lsb;

    assign redirect_base       = {redirect_pc[PC_SIZE-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // In-flight plus buffered never exceeds the FIFO, so every response has a slot.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response landing in the redirect cycle belongs to the old path.
    assign push              = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign outstanding_after = outstanding - CW'(imem_rsp_valid);

    assign if_valid = !rst && !fifo_empty && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign if_instr = head.instr[DATA_WIDTH-1:0];
    assign if_pc    = head.pc[PC_SIZE-1:0];

    assign push_entry.pc    = XLEN'(rsp_pc);
    assign push_entry.instr = XLEN'(imem_rsp_data);

    if (PC_SIZE < XLEN) begin : g_pc_pad
        logic unused_pc_hi;
        assign unused_pc_hi = ^head.pc[XLEN-1:PC_SIZE];
    end
    if (DATA_WIDTH < XLEN) begin : g_instr_pad
        logic unused_instr_hi;
        assign unused_instr_hi = ^head.instr[XLEN-1:DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= PC_SIZE'(RESET_PC);
            rsp_pc      <= PC_SIZE'(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_after + CW'(req_fire);
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                drop_cnt <= outstanding_after;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_SIZE'(INSTR_BYTES);
                if (push)     rsp_pc   <= rsp_pc + PC_SIZE'(INSTR_BYTES);
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    pak_rv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

`ifdef FETCH_PERF_EN
    // On redirect: buffered entries plus in-flight responses not already marked for drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid) begin
                perf_flushed <= perf_flushed + 32'(count) + 32'(outstanding - drop_cnt);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid) begin
            assert (outstanding != '0 || drop_cnt != '0);
        end
        if (!rst && push && !pop) begin
            assert (!fifo_full);
        end
    end

endmodule

// File: tb/tb_pak_rv_fetch_unit.sv
// Scoreboard bench for pak_rv_fetch_unit; also checks the perf counters when FETCH_PERF_EN is defined.
module tb_pak_rv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready;
    logic [9:0]  req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;

    logic        w_req_valid, w_rsp_valid, w_if_valid;
    logic [9:0]  w_req_addr, w_if_pc;
    logic [31:0] w_rsp_data, w_if_instr;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] instr;
    } exp_t;
    typedef struct {
        logic [9:0] addr;
        int         due;
    } mreq_t;

    exp_t       exp_q[$];
    mreq_t      mq[$];
    logic [9:0] exp_next = '0;
    logic [9:0] exp_req  = '0;
    int         lat_min = 1, lat_max = 1, last_due = 0;
    int         n_pops = 0, n_fires = 0, n_rsp = 0;
    int         first_valid = -1, redir_cyc = 0;
    logic       prev_redir = 1'b0;
    logic [9:0] w_addrs[$];
    logic [9:0] w_pcs[$];
    logic [31:0] w_instrs[$];

    pak_rv_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    pak_rv_fetch_unit #(
        .RESET_PC (32'h3FC)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (w_req_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .redirect_valid (1'b0),
        .redirect_pc    (10'h000),
        .if_valid       (w_if_valid),
        .if_ready       (1'b1),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (w_perf_fetched),
        .perf_flushed   (w_perf_flushed)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {a, 22'h0} ^ (32'h9E37_79B1 * (32'(a) + 32'd1));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Fixed 1-cycle imem for the wrap instance.
    always @(posedge clk) begin
        if (rst) begin
            w_rsp_valid <= 1'b0;
        end else begin
            w_rsp_valid <= w_req_valid;
            w_rsp_data  <= mem_word(w_req_addr);
        end
    end

    // Monitor: observes handshakes mid-cycle and pops the scoreboard.
    always @(negedge clk) begin
        int   due;
        exp_t e;
        if (rst) begin
            check("reset_req_valid", 64'(req_valid), 64'd0);
            check("reset_if_valid", 64'(if_valid), 64'd0);
            prev_redir = 1'b0;
        end else begin
            if (w_req_valid && w_addrs.size() < 3) w_addrs.push_back(w_req_addr);
            if (w_if_valid && w_pcs.size() < 3) begin
                w_pcs.push_back(w_if_pc);
                w_instrs.push_back(w_if_instr);
            end
            if (prev_redir) check("redirect_bubble_if_valid", 64'(if_valid), 64'd0);
            if (redirect_valid) begin
                check("redirect_if_valid", 64'(if_valid), 64'd0);
                check("redirect_req_valid", 64'(req_valid), 64'd0);
            end
            if (rsp_valid) n_rsp++;
            if (req_valid && req_ready) begin
                check("req_addr", 64'(req_addr), 64'(exp_req));
                exp_req = exp_req + 10'd4;
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{req_addr, due});
                n_fires++;
            end
            if (if_valid && first_valid < 0) first_valid = cyc;
            if (if_valid && if_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got pc 0x%0h, required none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", 64'(if_pc), 64'(e.pc));
                    check("if_instr", 64'(if_instr), 64'(e.instr));
                end
            end
            prev_redir = redirect_valid;
        end
    end

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{exp_next, mem_word(exp_next)});
            exp_next = exp_next + 10'd4;
        end
    endtask

    // Advance one cycle; the imem model returns in-order responses when due.
    task automatic step();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            rsp_valid = 1'b0;
        end
        refill();
    endtask

    task automatic do_reset();
        step();
        rst            = 1'b1;
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        mq.delete();
        exp_q.delete();
        exp_next    = '0;
        exp_req     = '0;
        last_due    = 0;
        n_pops      = 0;
        n_rsp       = 0;
        first_valid = -1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_reset_req_valid", 64'(req_valid), 64'd1);
        check("post_reset_req_addr", 64'(req_addr), 64'h000);
    endtask

    task automatic do_redirect(input logic [9:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        exp_next    = {tgt[9:2], 2'b00};
        exp_req     = {tgt[9:2], 2'b00};
        redir_cyc   = cyc;
        first_valid = -1;
        refill();
    endtask

    initial begin
        int f0;
        req_ready      = 1'b0;
        if_ready       = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset, then streaming with a 1-cycle imem: one instruction per cycle.
        do_reset();
        req_ready = 1'b1;
        if_ready  = 1'b1;
        repeat (3) step();
        f0 = n_pops;
        repeat (20) step();
        check("stream_rate", 64'(n_pops - f0), 64'd20);

        // Backpressure: only FIFO_DEPTH requests, then one more per pop.
        if_ready = 1'b0;
        do_reset();
        f0 = n_fires;
        repeat (10) step();
        #1;
        check("bp_fire_count", 64'(n_fires - f0), 64'd4);
        check("bp_req_valid_low", 64'(req_valid), 64'd0);
        f0 = n_fires;
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        repeat (6) step();
        check("bp_refill_count", 64'(n_fires - f0), 64'd1);

        // Redirect with two stale responses in flight on a 3-cycle imem.
        // Target request goes out next cycle, returns 3 cycles later, visible the cycle after.
        lat_min   = 3;
        lat_max   = 3;
        if_ready  = 1'b1;
        req_ready = 1'b0;
        do_reset();
        req_ready = 1'b1;
        step();
        step();
        do_redirect(10'h100);
        repeat (8) step();
        check("redirect_latency", 64'(first_valid - redir_cyc), 64'd5);

        // Misaligned target coincident with a response and if_ready.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        repeat (5) step();
        do_redirect(10'h102);
        step();
        #1;
        check("align_req_valid", 64'(req_valid), 64'd1);
        check("align_req_addr", 64'(req_addr), 64'h100);
        check("coincide_empty", 64'(if_valid), 64'd0);
        repeat (6) step();

        // Randomized traffic, redirects and a mid-run reset.
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step();
            req_ready = ($urandom_range(3) != 0);
            if_ready  = ($urandom_range(9) < 7);
            if (i == 1500) do_reset();
            else if ($urandom_range(24) == 0) do_redirect(10'($urandom_range(1023)));
        end

        // Drain: stop fetching, flush, let in-flight responses return.
        step();
        req_ready = 1'b0;
        if_ready  = 1'b0;
        do_redirect(10'h000);
        repeat (20) step();
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 64'(n_pops));
        check("perf_flushed", 64'(perf_flushed), 64'(n_rsp - n_pops));
`endif

        // Wrap instance: RESET_PC = 0x3FC on a 1 KB imem.
        check("wrap_addr_count", 64'(w_addrs.size()), 64'd3);
        check("wrap_pc_count", 64'(w_pcs.size()), 64'd3);
        if (w_addrs.size() == 3 && w_pcs.size() == 3) begin
            logic [9:0] wexp[3];
            wexp = '{10'h3FC, 10'h000, 10'h004};
            for (int k = 0; k < 3; k++) begin
                check("wrap_req_addr", 64'(w_addrs[k]), 64'(wexp[k]));
                check("wrap_if_pc", 64'(w_pcs[k]), 64'(wexp[k]));
                check("wrap_if_instr", 64'(w_instrs[k]), 64'(mem_word(wexp[k])));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
